// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the memory access sequencer.
package mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_seq_state_t;

    localparam int TIMEOUT_CYCLES_DEF = 15;

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    localparam int TIMEOUT_CNT_W = cnt_width(TIMEOUT_CYCLES_DEF);

endpackage

// File: rtl/mem_access_sequencer_timeout.sv
// Watchdog for unacknowledged requests; built only with MEM_TIMEOUT_EN.
module mem_timeout_counter
    import mem_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires during the REQ cycle whose increment would reach TIMEOUT_CYCLES.
    assign expired = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/mem_access_sequencer.sv
// Decoder-to-memory req/ack sequencer with core stall; watchdog abort under MEM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a load/store strobe; stall follows the strobe
// REQ   | mem_req held with stable address/data until ack (or timeout)
// DONE  | core released for one cycle so the instruction retires
module mem_access_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_read,
    input  logic              MEM_write,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              stall,
    output logic [DATA_W-1:0] rdata_out,
    output logic              rdata_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_err
);

    mem_seq_state_t    state_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              err_q;

    logic              strobe;
    logic              timeout;

    assign strobe = MEM_read | MEM_write;

`ifdef MEM_TIMEOUT_EN
    mem_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  ((state_q == IDLE) && strobe),
        .enable ((state_q == REQ) && !mem_ack),
        .expired(timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (strobe) begin
                        addr_q  <= addr_in;
                        wdata_q <= wdata_in;
                        we_q    <= MEM_write;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    // A real ack takes precedence over a coincident timeout.
                    if (mem_ack) begin
                        if (!we_q) begin
                            rdata_q  <= mem_rdata;
                            rvalid_q <= 1'b1;
                        end
                        req_q   <= 1'b0;
                        state_q <= DONE;
                    end else if (timeout) begin
                        if (!we_q) begin
                            rdata_q  <= '0;
                            rvalid_q <= 1'b1;
                        end
                        err_q   <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stall       = !rst && (((state_q == IDLE) && strobe) || (state_q == REQ));
    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign rdata_out   = rdata_q;
    assign rdata_valid = rvalid_q;
    assign mem_err     = err_q;

endmodule
